// File: rtl/c2c_r_arbiter_if.sv
// Read-channel bundle shared by the requesting masters, the arbiter and the slave port.
// The master modport is the environment's view; the slave modport is the arbiter's view.
interface c2c_r_arbiter_if #(
  parameter int XLEN      = 32,
  parameter int N_MASTERS = 2
);
  logic [N_MASTERS-1:0]      m_re;
  logic [N_MASTERS*XLEN-1:0] m_addr;
  logic [N_MASTERS-1:0]      m_ack;
  logic [N_MASTERS-1:0]      m_err;
  logic [XLEN-1:0]           m_data;
  logic                      s_re;
  logic [XLEN-1:0]           s_addr;
  logic                      s_ack;
  logic [XLEN-1:0]           s_data;

  modport master (
    output m_re, m_addr, s_ack, s_data,
    input  m_ack, m_err, m_data, s_re, s_addr
  );

  modport slave (
    input  m_re, m_addr, s_ack, s_data,
    output m_ack, m_err, m_data, s_re, s_addr
  );
endinterface

// File: rtl/c2c_r_arbiter.sv
// N-way read arbiter: one outstanding request forwarded to a single slave port,
// round-robin or fixed priority, with a watchdog that aborts unanswered requests.
module c2c_r_arbiter #(
  parameter int XLEN        = 32,
  parameter int N_MASTERS   = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic           clk,
  input  logic           reset_n,
  c2c_r_arbiter_if.slave bus
);
  localparam int GW = $clog2(N_MASTERS);
  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX   = (TIMEOUT == 0) ? {CW{1'b1}} : CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ABORT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_RST  = GW'(N_MASTERS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               r_state, w_nextState;
  logic [XLEN-1:0]      r_sAddr, w_nextAddr, w_winAddr;
  logic [GW-1:0]        r_grant, w_nextGrant;
  logic [GW-1:0]        r_last, w_nextLast;
  logic [GW-1:0]        w_winner, w_lowAny, w_lowAbove;
  logic                 w_hasAbove;
  logic [CW-1:0]        r_count, w_nextCount;
  logic                 w_timeout;
  logic [N_MASTERS-1:0] w_grantOh;

  // Descending scan leaves the lowest requester overall and the lowest one above
  // the last grant; round-robin prefers the latter, which is the wrap-around scan.
  always_comb begin
    w_lowAny   = '0;
    w_lowAbove = '0;
    w_hasAbove = 1'b0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (bus.m_re[i]) begin
        w_lowAny = GW'(i);
        if (GW'(i) > r_last) begin
          w_lowAbove = GW'(i);
          w_hasAbove = 1'b1;
        end
      end
    end
    w_winner = ((ROUND_ROBIN != 0) && w_hasAbove) ? w_lowAbove : w_lowAny;
  end

  always_comb begin
    w_winAddr = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (w_winner == GW'(i)) begin
        w_winAddr = bus.m_addr[i*XLEN +: XLEN];
      end
    end
  end

  assign w_grantOh = {{(N_MASTERS-1){1'b0}}, 1'b1} << r_grant;
  assign w_timeout = (TIMEOUT != 0) && (r_count == CNT_ABORT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_sAddr <= '0;
      r_grant <= '0;
      r_last  <= LAST_RST;
      r_count <= '0;
    end else begin
      r_state <= w_nextState;
      r_sAddr <= w_nextAddr;
      r_grant <= w_nextGrant;
      r_last  <= w_nextLast;
      r_count <= w_nextCount;
    end
  end

  // An ack in the abort cycle wins over the watchdog.
  always_comb begin
    w_nextState = r_state;
    w_nextAddr  = r_sAddr;
    w_nextGrant = r_grant;
    w_nextLast  = r_last;
    w_nextCount = r_count;
    bus.m_ack   = '0;
    bus.m_err   = '0;
    case (r_state)
      IDLE: begin
        if (|bus.m_re) begin
          w_nextState = BUSY;
          w_nextAddr  = w_winAddr;
          w_nextGrant = w_winner;
          w_nextCount = '0;
          if (ROUND_ROBIN != 0) begin
            w_nextLast = w_winner;
          end
        end
      end
      BUSY: begin
        if (bus.s_ack) begin
          bus.m_ack   = w_grantOh;
          w_nextState = IDLE;
        end else if (w_timeout) begin
          bus.m_err   = w_grantOh;
          w_nextState = IDLE;
        end else if (r_count != CNT_MAX) begin
          w_nextCount = r_count + 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign bus.s_re   = (r_state == BUSY);
  assign bus.s_addr = r_sAddr;
  assign bus.m_data = bus.s_data;
endmodule

// File: tb/tb_c2c_r_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same random traffic and
// compares their ack/err events against a transaction-level reference model.
module tb_c2c_r_arbiter;
  localparam int XLEN    = 32;
  localparam int N       = 3;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  c2c_r_arbiter_if #(.XLEN(XLEN), .N_MASTERS(N)) ifRr ();
  c2c_r_arbiter_if #(.XLEN(XLEN), .N_MASTERS(N)) ifFp ();

  c2c_r_arbiter #(.XLEN(XLEN), .N_MASTERS(N), .ROUND_ROBIN(1), .TIMEOUT(TIMEOUT)) dutRr (
    .clk(clk), .reset_n(reset_n), .bus(ifRr.slave)
  );
  c2c_r_arbiter #(.XLEN(XLEN), .N_MASTERS(N), .ROUND_ROBIN(0), .TIMEOUT(TIMEOUT)) dutFp (
    .clk(clk), .reset_n(reset_n), .bus(ifFp.slave)
  );

  assign ifFp.m_re   = ifRr.m_re;
  assign ifFp.m_addr = ifRr.m_addr;
  assign ifFp.s_ack  = ifRr.s_ack;
  assign ifFp.s_data = ifRr.s_data;

  typedef struct {
    int              cyc;
    bit              isErr;
    int              gRr;
    int              gFp;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] addrRr;
    logic [XLEN-1:0] addrFp;
  } evt_t;

  evt_t expQ[$];
  evt_t monEv;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   monOn = 1'b0;
  bit   expSRe = 1'b0;

  // Reference model state: master requests plus the single in-flight transaction.
  bit              pend[N];
  logic [XLEN-1:0] addr[N];
  bit              busy;
  int              busyCnt, ackAt, gRr, gFp, lastRr;
  logic [XLEN-1:0] tAddrRr, tAddrFp;
  logic [N-1:0]    reqMask;
  int              reqPct, ackMin, ackMax;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int rrPick();
    for (int k = 1; k <= N; k++) begin
      if (pend[(lastRr + k) % N]) return (lastRr + k) % N;
    end
    return 0;
  endfunction

  function automatic int lowestPick();
    for (int i = 0; i < N; i++) begin
      if (pend[i]) return i;
    end
    return 0;
  endfunction

  task automatic stepCycle();
    logic [N-1:0]      re;
    logic [N*XLEN-1:0] ad;
    int                doneIdx;
    evt_t              ev;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && reqMask[i] && ($urandom_range(99) < reqPct)) begin
        pend[i] = 1'b1;
        addr[i] = $urandom;
      end
      re[i] = pend[i];
      ad[i*XLEN +: XLEN] = addr[i];
    end
    ifRr.m_re   = re;
    ifRr.m_addr = ad;
    ifRr.s_data = $urandom;
    doneIdx = -1;
    if (!busy) begin
      expSRe = 1'b0;
      ifRr.s_ack = 1'($urandom_range(1));
      if (re != '0) begin
        gRr     = rrPick();
        gFp     = lowestPick();
        lastRr  = gRr;
        busy    = 1'b1;
        busyCnt = 0;
        ackAt   = $urandom_range(ackMax, ackMin);
        tAddrRr = addr[gRr];
        tAddrFp = addr[gFp];
      end
    end else begin
      busyCnt++;
      expSRe = 1'b1;
      ifRr.s_ack = (busyCnt == ackAt);
      if (busyCnt == ackAt || busyCnt == TIMEOUT) begin
        ev.cyc    = cyc;
        ev.isErr  = (busyCnt != ackAt);
        ev.gRr    = gRr;
        ev.gFp    = gFp;
        ev.data   = ifRr.s_data;
        ev.addrRr = tAddrRr;
        ev.addrFp = tAddrFp;
        expQ.push_back(ev);
        busy    = 1'b0;
        doneIdx = gRr;
      end
    end
    if (doneIdx >= 0) pend[doneIdx] = 1'b0;
  endtask

  task automatic applyStimulus(input int nCycles);
    for (int c = 0; c < nCycles; c++) stepCycle();
  endtask

  task automatic resetMidTransaction();
    reqMask = 3'b011;
    reqPct  = 100;
    ackMin  = TIMEOUT + 1;
    ackMax  = TIMEOUT + 2;
    for (int c = 0; c < 40 && !(busy && busyCnt == 1); c++) stepCycle();
    reset_n    = 1'b0;
    ifRr.s_ack = 1'b1;
    expSRe     = 1'b0;
    #1;
    checkOutput("rst_mid_s_re_rr", ifRr.s_re, 0);
    checkOutput("rst_mid_s_re_fp", ifFp.s_re, 0);
    checkOutput("rst_mid_m_ack_rr", ifRr.m_ack, 0);
    checkOutput("rst_mid_m_ack_fp", ifFp.m_ack, 0);
    checkOutput("rst_mid_m_err_rr", ifRr.m_err, 0);
    checkOutput("rst_mid_s_addr_rr", ifRr.s_addr, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    ifRr.m_re  = '0;
    ifRr.s_ack = 1'b0;
    reset_n    = 1'b1;
    busy       = 1'b0;
    lastRr     = N - 1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    pend[0] = 1'b1;
    addr[0] = $urandom;
    pend[1] = 1'b1;
    addr[1] = $urandom;
    reqMask = '0;
    ackMin  = 1;
    ackMax  = 1;
    applyStimulus(6);
  endtask

  // Scoreboard monitor: s_re every cycle, and an expected event for every ack/err pulse.
  always @(negedge clk) begin
    if (monOn) begin
      checkOutput("s_re_rr", ifRr.s_re, expSRe);
      checkOutput("s_re_fp", ifFp.s_re, expSRe);
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        monEv = expQ.pop_front();
        tests++;
        fails++;
        $display("[TB] FAIL missing_event: no pulse seen, expected %s for master %0d at cycle %0d",
                 monEv.isErr ? "m_err" : "m_ack", monEv.gRr, monEv.cyc);
      end
      if (|{ifRr.m_ack, ifRr.m_err, ifFp.m_ack, ifFp.m_err}) begin
        if (expQ.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_event: ack_rr=%b err_rr=%b ack_fp=%b err_fp=%b, expected none (cycle %0d)",
                   ifRr.m_ack, ifRr.m_err, ifFp.m_ack, ifFp.m_err, cyc);
        end else begin
          monEv = expQ.pop_front();
          checkOutput("event_cycle", cyc, monEv.cyc);
          checkOutput("m_ack_rr", ifRr.m_ack, monEv.isErr ? 0 : (32'd1 << monEv.gRr));
          checkOutput("m_err_rr", ifRr.m_err, monEv.isErr ? (32'd1 << monEv.gRr) : 0);
          checkOutput("m_ack_fp", ifFp.m_ack, monEv.isErr ? 0 : (32'd1 << monEv.gFp));
          checkOutput("m_err_fp", ifFp.m_err, monEv.isErr ? (32'd1 << monEv.gFp) : 0);
          checkOutput("s_addr_rr", ifRr.s_addr, monEv.addrRr);
          checkOutput("s_addr_fp", ifFp.s_addr, monEv.addrFp);
          if (!monEv.isErr) begin
            checkOutput("m_data_rr", ifRr.m_data, monEv.data);
            checkOutput("m_data_fp", ifFp.m_data, monEv.data);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      addr[i] = '0;
    end
    busy    = 1'b0;
    busyCnt = 0;
    ackAt   = 1;
    lastRr  = N - 1;
    reqMask = '0;
    reqPct  = 0;
    ackMin  = 1;
    ackMax  = 1;
    ifRr.m_re   = '0;
    ifRr.m_addr = '0;
    ifRr.s_ack  = 1'b1;
    ifRr.s_data = 32'h1234abcd;
    #1;
    checkOutput("rst_s_re", ifRr.s_re, 0);
    checkOutput("rst_s_addr", ifRr.s_addr, 0);
    checkOutput("rst_m_ack_rr", ifRr.m_ack, 0);
    checkOutput("rst_m_ack_fp", ifFp.m_ack, 0);
    checkOutput("rst_m_err_rr", ifRr.m_err, 0);
    checkOutput("rst_m_data", ifRr.m_data, 32'h1234abcd);
    @(posedge clk);
    @(posedge clk);
    #1;
    ifRr.s_ack = 1'b0;
    reset_n = 1'b1;
    monOn = 1'b1;

    reqMask = 3'b001; reqPct = 100; ackMin = 3; ackMax = 3;
    applyStimulus(12);
    reqMask = 3'b111; ackMin = 1; ackMax = 1;
    applyStimulus(18);
    ackMin = TIMEOUT + 1; ackMax = TIMEOUT + 2;
    applyStimulus(20);
    ackMin = TIMEOUT; ackMax = TIMEOUT;
    applyStimulus(20);
    reqMask = 3'b110; ackMin = 1; ackMax = 2;
    applyStimulus(20);
    reqMask = 3'b111; reqPct = 40; ackMin = 1; ackMax = TIMEOUT + 2;
    applyStimulus(1500);
    resetMidTransaction();
    reqMask = 3'b111; reqPct = 40; ackMin = 1; ackMax = TIMEOUT + 2;
    applyStimulus(300);
    reqMask = '0; ackMin = 1; ackMax = 1;
    applyStimulus(24);

    @(negedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
